// File: rtl/atm_ledger_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | atm_ledger_arbiter: two-terminal round-robin arbiter over a shared ledger |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module atm_ledger_arbiter #(
  parameter logic [31:0] INIT_BALANCE = 32'h000186A0,
  parameter logic [15:0] PEER_ACCT    = 16'hD903,
  parameter logic [31:0] PEER_INIT    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [31:0] amt0,
  input  logic [31:0] amt1,
  input  logic [15:0] acct0,
  input  logic [15:0] acct1,
  output logic [1:0]  gnt,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        rsp_id,
  output logic [31:0] rsp_balance,
  output logic [31:0] balance_out,
  output logic [31:0] peer_balance_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] C_OP_QUERY    = 2'b00;
  localparam logic [1:0] C_OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] C_OP_WITHDRAW = 2'b10;
  localparam logic [1:0] C_OP_TRANSFER = 2'b11;

  localparam logic [1:0] C_ERR_OK       = 2'b00;
  localparam logic [1:0] C_ERR_FUNDS    = 2'b01;
  localparam logic [1:0] C_ERR_ACCOUNT  = 2'b10;
  localparam logic [1:0] C_ERR_OVERFLOW = 2'b11;

  state_t      r_state;
  logic        r_last;
  logic        r_win;
  logic [1:0]  r_op;
  logic [31:0] r_amt;
  logic [15:0] r_acct;
  logic [31:0] r_bal;
  logic [31:0] r_peer;
  logic [1:0]  r_gnt;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_code;
  logic        r_rsp_id;
  logic [31:0] r_rsp_bal;

  logic        w_winner;
  logic [1:0]  w_sel_op;
  logic [31:0] w_sel_amt;
  logic [15:0] w_sel_acct;
  logic [32:0] w_sum;
  logic [32:0] w_psum;
  logic [1:0]  w_code;
  logic [31:0] w_new_bal;
  logic [31:0] w_new_peer;

  // On a tie the terminal that was not served last wins.
  always_comb begin
    w_winner = 1'b0;
    case (req)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_sel_op   = r_win ? op1   : op0;
  assign w_sel_amt  = r_win ? amt1  : amt0;
  assign w_sel_acct = r_win ? acct1 : acct0;

  assign w_sum  = {1'b0, r_bal}  + {1'b0, r_amt};
  assign w_psum = {1'b0, r_peer} + {1'b0, r_amt};

  // Errors leave both new-balance values equal to the current ones.
  always_comb begin
    w_code     = C_ERR_OK;
    w_new_bal  = r_bal;
    w_new_peer = r_peer;
    case (r_op)
      C_OP_QUERY: begin
        w_code = C_ERR_OK;
      end
      C_OP_DEPOSIT: begin
        if (w_sum[32]) w_code = C_ERR_OVERFLOW;
        else           w_new_bal = w_sum[31:0];
      end
      C_OP_WITHDRAW: begin
        if (r_amt > r_bal) w_code = C_ERR_FUNDS;
        else               w_new_bal = r_bal - r_amt;
      end
      C_OP_TRANSFER: begin
        if (r_acct != PEER_ACCT) begin
          w_code = C_ERR_ACCOUNT;
        end else if (r_amt > r_bal) begin
          w_code = C_ERR_FUNDS;
        end else if (w_psum[32]) begin
          w_code = C_ERR_OVERFLOW;
        end else begin
          w_new_bal  = r_bal - r_amt;
          w_new_peer = w_psum[31:0];
        end
      end
      default: w_code = C_ERR_OK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_op      <= 2'b00;
      r_amt     <= 32'd0;
      r_acct    <= 16'd0;
      r_bal     <= INIT_BALANCE;
      r_peer    <= PEER_INIT;
      r_gnt     <= 2'b00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= 2'b00;
      r_rsp_id  <= 1'b0;
      r_rsp_bal <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_win   <= w_winner;
            r_last  <= w_winner;
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_gnt   <= 2'b00;
          r_op    <= w_sel_op;
          r_amt   <= w_sel_amt;
          r_acct  <= w_sel_acct;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_bal     <= w_new_bal;
          r_peer    <= w_new_peer;
          r_done    <= 1'b1;
          r_err     <= (w_code != C_ERR_OK);
          r_code    <= w_code;
          r_rsp_id  <= r_win;
          r_rsp_bal <= w_new_bal;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_code    <= 2'b00;
          r_rsp_id  <= 1'b0;
          r_rsp_bal <= 32'd0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt              = r_gnt;
  assign done             = r_done;
  assign err              = r_err;
  assign err_code         = r_code;
  assign rsp_id           = r_rsp_id;
  assign rsp_balance      = r_rsp_bal;
  assign balance_out      = r_bal;
  assign peer_balance_out = r_peer;
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_atm_ledger_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_atm_ledger_arbiter: directed self-checking bench for the ledger arbiter |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_atm_ledger_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  op0, op1;
  logic [31:0] amt0, amt1;
  logic [15:0] acct0, acct1;
  logic [1:0]  gnt;
  logic        done, err, rsp_id, busy;
  logic [1:0]  err_code;
  logic [31:0] rsp_balance, balance_out, peer_balance_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  t_gnt;
  logic        t_err, t_id;
  logic [1:0]  t_code;
  logic [31:0] t_rbal;
  int          t_lat;

  atm_ledger_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .op0              (op0),
    .op1              (op1),
    .amt0             (amt0),
    .amt1             (amt1),
    .acct0            (acct0),
    .acct1            (acct1),
    .gnt              (gnt),
    .done             (done),
    .err              (err),
    .err_code         (err_code),
    .rsp_id           (rsp_id),
    .rsp_balance      (rsp_balance),
    .balance_out      (balance_out),
    .peer_balance_out (peer_balance_out),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issues one request from IDLE and records the response; returns in IDLE.
  task automatic txn(input logic [1:0] r);
    bit seen;
    seen  = 1'b0;
    t_lat = 0;
    req   = r;
    tick();
    t_gnt = gnt;
    req   = 2'b00;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (done) begin
        seen   = 1'b1;
        t_lat  = i;
        t_err  = err;
        t_id   = rsp_id;
        t_code = err_code;
        t_rbal = rsp_balance;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    op0   = 2'b00; op1  = 2'b00;
    amt0  = 32'd0; amt1 = 32'd0;
    acct0 = 16'd0; acct1 = 16'd0;

    do_reset();
    check("rst_gnt",  {30'd0, gnt}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_rbal", rsp_balance, 32'd0);
    check("rst_bal",  balance_out, 32'd100000);
    check("rst_peer", peer_balance_out, 32'd0);

    // Withdraw 1000 with explicit cycle-by-cycle latency checks.
    op0 = 2'b10; amt0 = 32'd1000; req = 2'b01;
    tick();
    check("w_gnt_n1",  {30'd0, gnt}, 32'd1);
    check("w_busy_n1", {31'd0, busy}, 32'd1);
    req = 2'b00;
    tick();
    check("w_gnt_n2",  {30'd0, gnt}, 32'd0);
    check("w_done_n2", {31'd0, done}, 32'd0);
    amt0 = 32'd7;
    tick();
    check("w_done_n3", {31'd0, done}, 32'd1);
    check("w_err",     {31'd0, err}, 32'd0);
    check("w_rbal",    rsp_balance, 32'd99000);
    check("w_bal",     balance_out, 32'd99000);
    check("w_id",      {31'd0, rsp_id}, 32'd0);
    tick();
    check("w_done_n4", {31'd0, done}, 32'd0);
    check("w_busy_n4", {31'd0, busy}, 32'd0);
    check("w_rbal_n4", rsp_balance, 32'd0);

    // Query with nonzero amount must not move the balance.
    op1 = 2'b00; amt1 = 32'd55;
    txn(2'b10);
    check("q_gnt",  {30'd0, t_gnt}, 32'd2);
    check("q_id",   {31'd0, t_id}, 32'd1);
    check("q_err",  {31'd0, t_err}, 32'd0);
    check("q_rbal", t_rbal, 32'd99000);

    // Both requesting continuously: strict alternation starting at terminal 0.
    do_reset();
    op0 = 2'b00; op1 = 2'b00;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt", {30'd0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      check("rr_done", {31'd0, done}, 32'd1);
      check("rr_id",   {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    req = 2'b00;

    // Transfer entire balance to the peer, then repeat it.
    do_reset();
    op0 = 2'b11; acct0 = 16'hD903; amt0 = 32'd100000;
    txn(2'b01);
    check("x1_lat",  t_lat, 32'd1);
    check("x1_err",  {31'd0, t_err}, 32'd0);
    check("x1_rbal", t_rbal, 32'd0);
    check("x1_bal",  balance_out, 32'd0);
    check("x1_peer", peer_balance_out, 32'd100000);
    txn(2'b01);
    check("x2_err",  {31'd0, t_err}, 32'd1);
    check("x2_code", {30'd0, t_code}, 32'd1);
    check("x2_bal",  balance_out, 32'd0);
    check("x2_peer", peer_balance_out, 32'd100000);

    // Bad destination account.
    do_reset();
    op1 = 2'b11; acct1 = 16'h1234; amt1 = 32'd5;
    txn(2'b10);
    check("xa_gnt",  {30'd0, t_gnt}, 32'd2);
    check("xa_code", {30'd0, t_code}, 32'd2);
    check("xa_err",  {31'd0, t_err}, 32'd1);
    check("xa_peer", peer_balance_out, 32'd0);

    // Deposit overflow, then a legal deposit.
    do_reset();
    op1 = 2'b01; amt1 = 32'hFFFFFFFF;
    txn(2'b10);
    check("dov_code", {30'd0, t_code}, 32'd3);
    check("dov_bal",  balance_out, 32'd100000);
    amt1 = 32'd5;
    txn(2'b10);
    check("dep_code", {30'd0, t_code}, 32'd0);
    check("dep_bal",  balance_out, 32'd100005);

    // Withdraw boundaries: one over the balance, then exactly the balance.
    do_reset();
    op0 = 2'b10; amt0 = 32'd100001;
    txn(2'b01);
    check("wov_code", {30'd0, t_code}, 32'd1);
    check("wov_bal",  balance_out, 32'd100000);
    amt0 = 32'd100000;
    txn(2'b01);
    check("wex_err",  {31'd0, t_err}, 32'd0);
    check("wex_bal",  balance_out, 32'd0);

    // Reset during EXEC aborts the withdraw.
    do_reset();
    op0 = 2'b10; amt0 = 32'd500; req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    check("ab_done0", {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();
    check("ab_done1", {31'd0, done}, 32'd0);
    check("ab_busy",  {31'd0, busy}, 32'd0);
    check("ab_bal",   balance_out, 32'd100000);
    tick();
    tick();
    check("ab_done2", {31'd0, done}, 32'd0);
    check("ab_bal2",  balance_out, 32'd100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
